// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 defaults), coordinate type and a
// window helper used by the timing generator and by renderers.
package vga_timing_pkg;

   localparam int H_VISIBLE_DEF = 640;
   localparam int H_FRONT_DEF   = 16;
   localparam int H_SYNC_DEF    = 96;
   localparam int H_BACK_DEF    = 48;
   localparam int H_TOTAL_DEF   = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

   localparam int V_VISIBLE_DEF = 480;
   localparam int V_FRONT_DEF   = 10;
   localparam int V_SYNC_DEF    = 2;
   localparam int V_BACK_DEF    = 33;
   localparam int V_TOTAL_DEF   = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

   localparam int COORD_W = 10;
   typedef logic [COORD_W-1:0] coord_t;

   // True when pos lies in the half-open window [lo, lo+len).
   function automatic logic in_window(input int pos, input int lo, input int len);
      return (pos >= lo) && (pos < (lo + len));
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle: sync levels, blanking, pixel position and event pulses.
interface vga_timing_gen_if;
   import vga_timing_pkg::*;

   logic       hs;
   logic       vs;
   logic       blank;
   coord_t     DrawX;
   coord_t     DrawY;
   logic       line_start;
   logic       frame_start;
   logic       vblank_start;
   logic [7:0] frame_count;

   modport master (
      output hs, vs, blank, DrawX, DrawY,
      output line_start, frame_start, vblank_start, frame_count
   );

   modport slave (
      input hs, vs, blank, DrawX, DrawY,
      input line_start, frame_start, vblank_start, frame_count
   );

endinterface

// File: rtl/vga_timing_gen.sv
// VGA timing generator: horizontal/vertical counters advanced by a pixel clock
// enable, with every output registered on the same edge as the counters so
// position, sync and blanking never skew against each other.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_VISIBLE = H_VISIBLE_DEF,
   parameter int H_FRONT   = H_FRONT_DEF,
   parameter int H_SYNC    = H_SYNC_DEF,
   parameter int H_BACK    = H_BACK_DEF,
   parameter int V_VISIBLE = V_VISIBLE_DEF,
   parameter int V_FRONT   = V_FRONT_DEF,
   parameter int V_SYNC    = V_SYNC_DEF,
   parameter int V_BACK    = V_BACK_DEF
) (
   input  logic                    vga_clk,
   input  logic                    reset,
   input  logic                    pix_ce,
   vga_timing_gen_if.master        vid
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int HCW     = $clog2(H_TOTAL);
   localparam int VCW     = $clog2(V_TOTAL);

   logic [HCW-1:0] hc_r;
   logic [VCW-1:0] vc_r;
   logic [HCW-1:0] hc_nxt_s;
   logic [VCW-1:0] vc_nxt_s;
   logic           h_wrap_s;
   logic           blank_nxt_s;
   logic           hs_nxt_s;
   logic           vs_nxt_s;
   logic           line_start_nxt_s;
   logic           frame_start_nxt_s;
   logic           vblank_start_nxt_s;

   // Next counter position and the output levels/events that position implies.
   always_comb begin
      h_wrap_s = (hc_r == HCW'(H_TOTAL - 1));
      if (h_wrap_s) begin
         hc_nxt_s = HCW'(0);
         if (vc_r == VCW'(V_TOTAL - 1)) begin
            vc_nxt_s = VCW'(0);
         end else begin
            vc_nxt_s = vc_r + VCW'(1);
         end
      end else begin
         hc_nxt_s = hc_r + HCW'(1);
         vc_nxt_s = vc_r;
      end
      blank_nxt_s        = in_window(int'(hc_nxt_s), 0, H_VISIBLE) &&
                           in_window(int'(vc_nxt_s), 0, V_VISIBLE);
      hs_nxt_s           = !in_window(int'(hc_nxt_s), H_VISIBLE + H_FRONT, H_SYNC);
      vs_nxt_s           = !in_window(int'(vc_nxt_s), V_VISIBLE + V_FRONT, V_SYNC);
      line_start_nxt_s   = (hc_nxt_s == HCW'(0));
      frame_start_nxt_s  = (hc_nxt_s == HCW'(0)) && (vc_nxt_s == VCW'(0));
      vblank_start_nxt_s = (hc_nxt_s == HCW'(0)) && (vc_nxt_s == VCW'(V_VISIBLE));
   end

   // Horizontal counter: parks on the last column in reset so the first
   // enabled edge afterwards lands on column 0.
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         hc_r <= HCW'(H_TOTAL - 1);
      end else if (pix_ce) begin
         hc_r <= hc_nxt_s;
      end else begin
         hc_r <= hc_r;
      end
   end

   // Vertical counter: parks on the last line in reset, steps on line wrap.
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         vc_r <= VCW'(V_TOTAL - 1);
      end else if (pix_ce) begin
         vc_r <= vc_nxt_s;
      end else begin
         vc_r <= vc_r;
      end
   end

   // Registered outputs: levels follow the counters, pulses last one cycle.
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         vid.DrawX        <= COORD_W'(H_TOTAL - 1);
         vid.DrawY        <= COORD_W'(V_TOTAL - 1);
         vid.blank        <= 1'b0;
         vid.hs           <= 1'b1;
         vid.vs           <= 1'b1;
         vid.line_start   <= 1'b0;
         vid.frame_start  <= 1'b0;
         vid.vblank_start <= 1'b0;
         vid.frame_count  <= 8'hFF;
      end else if (pix_ce) begin
         vid.DrawX        <= COORD_W'(hc_nxt_s);
         vid.DrawY        <= COORD_W'(vc_nxt_s);
         vid.blank        <= blank_nxt_s;
         vid.hs           <= hs_nxt_s;
         vid.vs           <= vs_nxt_s;
         vid.line_start   <= line_start_nxt_s;
         vid.frame_start  <= frame_start_nxt_s;
         vid.vblank_start <= vblank_start_nxt_s;
         if (frame_start_nxt_s) begin
            vid.frame_count <= vid.frame_count + 8'd1;
         end else begin
            vid.frame_count <= vid.frame_count;
         end
      end else begin
         vid.DrawX        <= vid.DrawX;
         vid.DrawY        <= vid.DrawY;
         vid.blank        <= vid.blank;
         vid.hs           <= vid.hs;
         vid.vs           <= vid.vs;
         vid.line_start   <= 1'b0;
         vid.frame_start  <= 1'b0;
         vid.vblank_start <= 1'b0;
         vid.frame_count  <= vid.frame_count;
      end
   end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, meaning active pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 16, meaning horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, meaning hsync pulse width in pixels.
REQ-004 SHALL have parameter H_BACK, default 48, meaning horizontal back porch; H_TOTAL = sum of H_* (800).
REQ-005 SHALL have parameter V_VISIBLE, default 480, meaning active lines per frame.
REQ-006 SHALL have parameters V_FRONT, V_SYNC, V_BACK, defaults 10, 2, 33, meaning vertical porches and sync in lines; V_TOTAL = 525.
REQ-007 SHALL have port vga_clk, input, 1, meaning single clock domain; all logic on its rising edge.
REQ-008 SHALL have port reset, input, 1, meaning synchronous, active-high reset.
REQ-009 SHALL have port pix_ce, input, 1, meaning pixel clock enable; position advances only on edges with pix_ce=1.
REQ-010 SHALL have ports hs and vs, outputs, 1 each, meaning active-low sync pulses.
REQ-011 SHALL have port blank, output, 1, meaning 1 inside the visible region and 0 elsewhere (renderers drive colour only when blank=1).
REQ-012 SHALL have ports DrawX and DrawY, outputs, 10 each, meaning current pixel column and line.
REQ-013 SHALL have ports line_start, frame_start and vblank_start, outputs, 1 each, meaning single-cycle event pulses.
REQ-014 SHALL have port frame_count, output, 8, meaning count of frames started since reset.

Function
REQ-015 Horizontal counter hc SHALL count 0..H_TOTAL-1 and wrap to 0; vertical counter vc SHALL increment only when hc wraps, counting 0..V_TOTAL-1 and wrapping to 0.
REQ-016 Edges with pix_ce=0 SHALL hold hc, vc and all level outputs unchanged.
REQ-017 All outputs SHALL be registered and updated on the same edge as the counters, so DrawX=hc, DrawY=vc, hs, vs and blank are mutually consistent every cycle (zero relative skew).
REQ-018 blank SHALL be 1 iff hc < H_VISIBLE and vc < V_VISIBLE.
REQ-019 hs SHALL be 0 iff H_VISIBLE+H_FRONT <= hc < H_VISIBLE+H_FRONT+H_SYNC (656..751 at defaults).
REQ-020 vs SHALL be 0 iff V_VISIBLE+V_FRONT <= vc < V_VISIBLE+V_FRONT+V_SYNC (490..491 at defaults), for every hc of those lines.
REQ-021 line_start SHALL be 1 for exactly one vga_clk cycle following the edge on which hc becomes 0, including during vertical blanking lines.
REQ-022 frame_start SHALL be 1 for exactly one vga_clk cycle following the edge on which (hc,vc) becomes (0,0); it SHALL coincide with line_start.
REQ-023 vblank_start SHALL be 1 for exactly one vga_clk cycle following the edge on which (hc,vc) becomes (0,V_VISIBLE).
REQ-024 Pulses SHALL deassert on the next edge regardless of pix_ce, so a pulse never lasts more than one cycle.
REQ-025 frame_count SHALL increment modulo 256 on each edge that raises frame_start; 255 SHALL wrap to 0.
REQ-026 Counter arithmetic SHALL be sized from the parameters; at defaults hc and vc fit in 10 bits, and no output SHALL ever show hc >= H_TOTAL or vc >= V_TOTAL.

Reset
REQ-027 While reset=1, the following SHALL hold, overriding pix_ce: hc=H_TOTAL-1 and vc=V_TOTAL-1, so DrawX=799 and DrawY=524; blank=0; hs=1; vs=1; all pulses=0; frame_count=8'hFF.
REQ-028 The first pix_ce=1 edge after reset release SHALL move to (0,0) and raise frame_start and line_start, with frame_count=0 and blank=1.
REQ-029 Reset asserted mid-frame SHALL take effect on the next edge, with no partial sync pulse held past it.

Structure
REQ-030 Default timing constants and H_TOTAL/V_TOTAL derivations SHALL live in shared package vga_timing_pkg, which the renderers also import for visible width and height.
REQ-031 The block SHALL be a single module with no sub-module; horizontal and vertical counters SHALL be separate always_ff processes.

Verification
REQ-032 Reset for 3 cycles, then pix_ce=1 constantly: the cycle after release shows DrawX=0, DrawY=0, blank=1, frame_start=1, frame_count=0.
REQ-033 With pix_ce=1: consecutive frame_start pulses are 420000 cycles apart, and line_start pulses are 800 apart.
REQ-034 Each line: hs=0 for exactly 96 cycles starting at DrawX=656; blank falls at DrawX=640 and rises at DrawX=0 on lines 0..479 only.
REQ-035 vs=0 for exactly 2 lines (1600 cycles) starting at DrawY=490, hc=0; vblank_start fires once per frame at DrawY=480.
REQ-036 With pix_ce toggling 1,0,1,0: frame period is 840000 cycles, and every pulse stays exactly one cycle wide.
REQ-037 Reset asserted at DrawX=700, DrawY=490 (inside hs and vs): the next edge shows REQ-027 values with hs=1 and vs=1; after 256 frames, frame_count wraps from 255 to 0.
